ca_cmd_assembler: RTL and testbench

Host-side command assembler that sits directly upstream of the CA distributor in the RCD datapath. It samples the host DCA bus and chip selects each cycle and assembles 1-UI or 2-UI DDR5 commands into one CA word with its rank. It also checks DPAR parity, buffers completed commands in a first-word-fall-through FIFO, and presents them to the distributor on a valid/ready interface.

---
 rtl/ca_cmd_assembler.sv | 187 ++++++++++++++++++
 tb/tb_ca_cmd_assembler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ca_cmd_assembler.sv
// ca_cmd_assembler
//   Samples the host DCA bus and chip selects once per UI, assembles 1-UI or
//   2-UI DDR5 commands into a single CA word tagged with its rank, drops
//   commands with DPAR errors, and queues accepted words in a
//   first-word-fall-through FIFO toward the CA distributor.
//
// Ports
//   clk, rst_n         core clock (one UI per cycle), async active-low reset
//   enable             block enable; low aborts any partial command
//   par_check_en       enables DPAR checking
//   clear_stats        synchronous clear of counters and overflow flag
//   dcs_n, dca, dpar   host chip selects (active-low), CA bits, parity
//   ca_out, ca_rank_out, ca_valid_out, ca_ready_in   FIFO head, valid/ready
//   fifo_level         occupied FIFO entries
//   cmd_count          accepted commands (saturating)
//   par_err_count      parity-dropped commands (saturating)
//   par_err_pulse      one-cycle strobe after a parity drop
//   overflow_sticky    a command was dropped on a full FIFO
module ca_cmd_assembler #(
  parameter int DCA_WIDTH  = 7,
  parameter int CA_WIDTH   = 24,
  parameter int NUM_CS     = 2,
  parameter int RANK_BITS  = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int LVL_W     = $clog2(FIFO_DEPTH + 1),
  localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 par_check_en,
  input  logic                 clear_stats,
  input  logic [NUM_CS-1:0]    dcs_n,
  input  logic [DCA_WIDTH-1:0] dca,
  input  logic                 dpar,
  output logic [CA_WIDTH-1:0]  ca_out,
  output logic [RANK_BITS-1:0] ca_rank_out,
  output logic                 ca_valid_out,
  input  logic                 ca_ready_in,
  output logic [LVL_W-1:0]     fifo_level,
  output logic [15:0]          cmd_count,
  output logic [15:0]          par_err_count,
  output logic                 par_err_pulse,
  output logic                 overflow_sticky
);

  typedef enum logic {IDLE, UI1} state_t;

  state_t state_q, state_d;

  // UI0 context held across the UI0 -> UI1 boundary
  logic [DCA_WIDTH-1:0] ui0_p0;
  logic [RANK_BITS-1:0] rank_p0;
  logic                 bad_p0;

  logic [CA_WIDTH-1:0]  mem_data [FIFO_DEPTH];
  logic [RANK_BITS-1:0] mem_rank [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]     count;

  logic                 bad_now;
  logic [RANK_BITS-1:0] rank_now;
  logic                 latch_ui0;
  logic                 done;
  logic                 done_bad;
  logic [CA_WIDTH-1:0]  word;
  logic [RANK_BITS-1:0] word_rank;
  logic                 full, pop, push, ovf;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign bad_now = par_check_en && (^{dca, dpar});

  // Lowest-numbered asserted chip select wins
  always_comb begin
    rank_now = '0;
    for (int i = NUM_CS - 1; i >= 0; i--) begin
      if (!dcs_n[i]) rank_now = RANK_BITS'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    latch_ui0 = 1'b0;
    done      = 1'b0;
    done_bad  = 1'b0;
    word      = '0;
    word_rank = rank_now;
    if (!enable) begin
      // Partial 2-UI command is abandoned without any bookkeeping
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!(&dcs_n)) begin
            if (dca[2:0] == 3'b111) begin
              done                  = 1'b1;
              done_bad              = bad_now;
              word[DCA_WIDTH-1:0]   = dca;
            end else begin
              latch_ui0 = 1'b1;
              state_d   = UI1;
            end
          end
        end
        UI1: begin
          done                                = 1'b1;
          done_bad                            = bad_p0 | bad_now;
          word[DCA_WIDTH-1:0]                 = ui0_p0;
          word[2*DCA_WIDTH-1:DCA_WIDTH]       = dca;
          word[2*DCA_WIDTH]                   = 1'b1;
          word_rank                           = rank_p0;
          state_d                             = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (latch_ui0) begin
      ui0_p0  <= dca;
      rank_p0 <= rank_now;
      bad_p0  <= bad_now;
    end
  end

  // FIFO: a push into a full FIFO is legal only when the head leaves this cycle
  assign full = (count == LVL_W'(FIFO_DEPTH));
  assign pop  = ca_valid_out && ca_ready_in;
  assign push = done && !done_bad && (!full || pop);
  assign ovf  = done && !done_bad && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= word;
      mem_rank[wr_ptr] <= word_rank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + LVL_W'(1);
      else if (pop && !push) count <= count - LVL_W'(1);
    end
  end

  assign ca_valid_out = (count != '0);
  assign fifo_level   = count;
  assign ca_out       = ca_valid_out ? mem_data[rd_ptr] : '0;
  assign ca_rank_out  = ca_valid_out ? mem_rank[rd_ptr] : '0;

  // Statistics: clear_stats takes priority over any same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_count       <= '0;
      par_err_count   <= '0;
      par_err_pulse   <= 1'b0;
      overflow_sticky <= 1'b0;
    end else begin
      par_err_pulse <= done && done_bad;
      if (clear_stats) begin
        cmd_count       <= '0;
        par_err_count   <= '0;
        overflow_sticky <= 1'b0;
      end else begin
        if (push)             cmd_count       <= sat_inc(cmd_count);
        if (done && done_bad) par_err_count   <= sat_inc(par_err_count);
        if (ovf)              overflow_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ca_cmd_assembler.sv
module tb_ca_cmd_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        par_check_en;
  logic        clear_stats;
  logic [1:0]  dcs_n;
  logic [6:0]  dca;
  logic        dpar;
  logic [23:0] ca_out;
  logic [3:0]  ca_rank_out;
  logic        ca_valid_out;
  logic        ca_ready_in;
  logic [2:0]  fifo_level;
  logic [15:0] cmd_count;
  logic [15:0] par_err_count;
  logic        par_err_pulse;
  logic        overflow_sticky;

  int checks = 0;
  int errors = 0;

  ca_cmd_assembler dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .par_check_en    (par_check_en),
    .clear_stats     (clear_stats),
    .dcs_n           (dcs_n),
    .dca             (dca),
    .dpar            (dpar),
    .ca_out          (ca_out),
    .ca_rank_out     (ca_rank_out),
    .ca_valid_out    (ca_valid_out),
    .ca_ready_in     (ca_ready_in),
    .fifo_level      (fifo_level),
    .cmd_count       (cmd_count),
    .par_err_count   (par_err_count),
    .par_err_pulse   (par_err_pulse),
    .overflow_sticky (overflow_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are settled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] cs, input logic [6:0] d, input logic good);
    dcs_n = cs;
    dca   = d;
    dpar  = good ? ^d : ~(^d);
  endtask

  task automatic idle();
    dcs_n = 2'b11;
    dca   = 7'h00;
    dpar  = 1'b0;
  endtask

  logic [6:0] exp_q [$];

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b1;
    par_check_en = 1'b1;
    clear_stats  = 1'b0;
    ca_ready_in  = 1'b1;
    idle();
    repeat (2) step();
    chk("rst_valid",  32'(ca_valid_out),    32'd0);
    chk("rst_level",  32'(fifo_level),      32'd0);
    chk("rst_ca",     32'(ca_out),          32'd0);
    chk("rst_rank",   32'(ca_rank_out),     32'd0);
    chk("rst_cmd",    32'(cmd_count),       32'd0);
    chk("rst_perr",   32'(par_err_count),   32'd0);
    chk("rst_pulse",  32'(par_err_pulse),   32'd0);
    chk("rst_sticky", 32'(overflow_sticky), 32'd0);
    rst_n = 1'b1;
    step();

    // 1-UI command on CS0
    drive(2'b10, 7'h7F, 1'b1);
    step();
    idle();
    chk("u1_valid", 32'(ca_valid_out), 32'd1);
    chk("u1_ca",    32'(ca_out),       32'h00007F);
    chk("u1_rank",  32'(ca_rank_out),  32'd0);
    chk("u1_cmd",   32'(cmd_count),    32'd1);
    chk("u1_level", 32'(fifo_level),   32'd1);
    step();
    chk("u1_drain", 32'(ca_valid_out), 32'd0);

    // 2-UI command on CS1
    drive(2'b01, 7'h00, 1'b1);
    step();
    chk("u2_mid_valid", 32'(ca_valid_out), 32'd0);
    drive(2'b11, 7'h55, 1'b1);
    step();
    idle();
    chk("u2_valid", 32'(ca_valid_out), 32'd1);
    chk("u2_ca",    32'(ca_out),       32'h006A80);
    chk("u2_rank",  32'(ca_rank_out),  32'd1);
    chk("u2_cmd",   32'(cmd_count),    32'd2);
    step();

    // Bad UI1 parity
    drive(2'b01, 7'h00, 1'b1);
    step();
    drive(2'b11, 7'h55, 1'b0);
    step();
    idle();
    chk("pe_valid", 32'(ca_valid_out),  32'd0);
    chk("pe_count", 32'(par_err_count), 32'd1);
    chk("pe_pulse", 32'(par_err_pulse), 32'd1);
    chk("pe_cmd",   32'(cmd_count),     32'd2);
    step();
    chk("pe_pulse_off", 32'(par_err_pulse), 32'd0);

    // Bad parity on a 1-UI command
    drive(2'b10, 7'h7F, 1'b0);
    step();
    idle();
    chk("pe1_count", 32'(par_err_count), 32'd2);
    chk("pe1_valid", 32'(ca_valid_out),  32'd0);
    step();

    // Same bad UI1 with checking disabled is accepted
    par_check_en = 1'b0;
    drive(2'b01, 7'h00, 1'b1);
    step();
    drive(2'b11, 7'h55, 1'b0);
    step();
    idle();
    chk("pd_valid", 32'(ca_valid_out),  32'd1);
    chk("pd_ca",    32'(ca_out),        32'h006A80);
    chk("pd_cmd",   32'(cmd_count),     32'd3);
    chk("pd_perr",  32'(par_err_count), 32'd2);
    step();
    par_check_en = 1'b1;

    // Clear statistics
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    chk("clr_cmd",  32'(cmd_count),     32'd0);
    chk("clr_perr", 32'(par_err_count), 32'd0);

    // Overflow: five 1-UI commands into a blocked FIFO
    ca_ready_in = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      drive(2'b10, 7'((i << 3) | 7), 1'b1);
      if (i < 4) exp_q.push_back(7'((i << 3) | 7));
      step();
    end
    idle();
    chk("ov_level",  32'(fifo_level),      32'd4);
    chk("ov_sticky", 32'(overflow_sticky), 32'd1);
    chk("ov_cmd",    32'(cmd_count),       32'd4);
    chk("ov_head",   32'(ca_out),          32'h000007);
    step();
    chk("ov_hold",   32'(ca_out),          32'h000007);
    ca_ready_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("ov_order", 32'(ca_out), 32'(exp_q[k]));
      step();
    end
    chk("ov_empty", 32'(fifo_level), 32'd0);
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    chk("ov_clr_cmd",    32'(cmd_count),       32'd0);
    chk("ov_clr_sticky", 32'(overflow_sticky), 32'd0);

    // Full FIFO with simultaneous push and pop
    ca_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 7'(8'h47 + 8'(i << 3)), 1'b1);
      step();
    end
    chk("fp_full", 32'(fifo_level), 32'd4);
    ca_ready_in = 1'b1;
    drive(2'b10, 7'h3F, 1'b1);
    step();
    idle();
    chk("fp_level",  32'(fifo_level),      32'd4);
    chk("fp_sticky", 32'(overflow_sticky), 32'd0);
    chk("fp_cmd",    32'(cmd_count),       32'd5);
    exp_q.delete();
    exp_q.push_back(7'h4F);
    exp_q.push_back(7'h57);
    exp_q.push_back(7'h5F);
    exp_q.push_back(7'h3F);
    for (int k = 0; k < 4; k++) begin
      chk("fp_order", 32'(ca_out), 32'(exp_q[k]));
      step();
    end
    chk("fp_empty", 32'(fifo_level), 32'd0);

    // Abort: enable drops during UI1
    drive(2'b01, 7'h00, 1'b1);
    step();
    enable = 1'b0;
    drive(2'b11, 7'h55, 1'b1);
    step();
    enable = 1'b1;
    idle();
    chk("ab_valid", 32'(ca_valid_out),  32'd0);
    chk("ab_cmd",   32'(cmd_count),     32'd5);
    chk("ab_perr",  32'(par_err_count), 32'd0);
    step();
    chk("ab_valid2", 32'(ca_valid_out), 32'd0);
    drive(2'b10, 7'h17, 1'b1);
    step();
    idle();
    chk("ab_next", 32'(ca_out), 32'h000017);
    step();

    // Asynchronous reset with two entries queued
    ca_ready_in = 1'b0;
    drive(2'b10, 7'h0F, 1'b1);
    step();
    drive(2'b01, 7'h1F, 1'b1);
    step();
    idle();
    chk("ar_level", 32'(fifo_level), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(ca_valid_out), 32'd0);
    chk("ar_lvl0",  32'(fifo_level),   32'd0);
    chk("ar_cmd",   32'(cmd_count),    32'd0);
    step();
    rst_n = 1'b1;
    ca_ready_in = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
